// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename package: physical/architectural register counts and the preg type
// used by rename, commit and the free list.
package phys_reg_free_list_pkg;

    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int PREG_W    = $clog2(NUM_PREGS);
    localparam int FL_DEPTH  = NUM_PREGS - 1;
    localparam int PTR_W     = $clog2(FL_DEPTH);
    localparam int CNT_W     = PREG_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical registers: offers two pregs per cycle to rename,
// absorbs up to two released pregs from commit, and flags illegal releases.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        alloc_req,
    output logic              alloc_grant,
    output logic [PREG_W-1:0] alloc_preg0,
    output logic [PREG_W-1:0] alloc_preg1,
    input  logic [1:0]        rel_valid,
    input  logic [PREG_W-1:0] rel_preg0,
    input  logic [PREG_W-1:0] rel_preg1,
    output logic [CNT_W-1:0]  free_count,
    output logic              err_release
);

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    // The buffer is FL_DEPTH (not a power of two) deep, so wrap by compare-and-subtract.
    function automatic ptr_t wrap_inc(input ptr_t ptr, input logic [1:0] n);
        logic [PTR_W:0] sum;
        sum = {1'b0, ptr} + {{(PTR_W-1){1'b0}}, n};
        if (sum >= (PTR_W+1)'(FL_DEPTH)) begin
            sum = sum - (PTR_W+1)'(FL_DEPTH);
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    function automatic logic [NUM_PREGS-1:0] onehot(input logic en, input preg_t p);
        logic [NUM_PREGS-1:0] m;
        m    = '0;
        m[p] = en;
        return m;
    endfunction

    preg_t                fl_q [FL_DEPTH];
    ptr_t                 head_q, head_d;
    ptr_t                 tail_q, tail_d;
    cnt_t                 count_q, count_d;
    logic [NUM_PREGS-1:0] bitmap_q, bitmap_d;
    logic                 err_q, err_d;

    logic [1:0]           req_cnt_s;
    logic [1:0]           pop_n_s;
    logic [1:0]           acc_n_s;
    logic                 grant_s;
    logic                 acc0_s, acc1_s;
    ptr_t                 head1_s;
    ptr_t                 wr1_idx_s;
    cnt_t                 post_pop_s;
    logic [NUM_PREGS-1:0] clr_mask_s, set_mask_s;

    // Offer, grant and release-legality decisions, all from current state.
    always_comb begin
        req_cnt_s   = popcount2(alloc_req);
        // Grant ignores this cycle's releases: an empty list stalls even if commit frees.
        grant_s     = count_q >= {{(CNT_W-2){1'b0}}, req_cnt_s};
        pop_n_s     = grant_s ? req_cnt_s : 2'd0;
        head1_s     = wrap_inc(head_q, {1'b0, alloc_req[0]});
        alloc_preg0 = fl_q[head_q];
        alloc_preg1 = fl_q[head1_s];
        alloc_grant = grant_s;
        post_pop_s  = count_q - cnt_t'(pop_n_s);

        acc0_s = rel_valid[0] && (rel_preg0 != '0) && !bitmap_q[rel_preg0]
                 && (post_pop_s < cnt_t'(FL_DEPTH));
        acc1_s = rel_valid[1] && (rel_preg1 != '0) && !bitmap_q[rel_preg1]
                 && !(rel_valid[0] && (rel_preg0 == rel_preg1))
                 && ((post_pop_s + cnt_t'(acc0_s)) < cnt_t'(FL_DEPTH));
        acc_n_s   = popcount2({acc1_s, acc0_s});
        wr1_idx_s = wrap_inc(tail_q, {1'b0, acc0_s});

        clr_mask_s = onehot(grant_s && alloc_req[0], alloc_preg0)
                   | onehot(grant_s && alloc_req[1], alloc_preg1);
        set_mask_s = onehot(acc0_s, rel_preg0) | onehot(acc1_s, rel_preg1);

        head_d   = wrap_inc(head_q, pop_n_s);
        tail_d   = wrap_inc(tail_q, acc_n_s);
        count_d  = post_pop_s + cnt_t'(acc_n_s);
        bitmap_d = (bitmap_q & ~clr_mask_s) | set_mask_s;
        err_d    = err_q || (rel_valid[0] && !acc0_s) || (rel_valid[1] && !acc1_s);
    end

    // State update; reset loads p32..p63 as the free list with p0..p31 architecturally mapped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= (i < NUM_PREGS - NUM_AREGS) ? preg_t'(NUM_AREGS + i) : '0;
            end
            head_q   <= '0;
            tail_q   <= ptr_t'(NUM_PREGS - NUM_AREGS);
            count_q  <= cnt_t'(NUM_PREGS - NUM_AREGS);
            bitmap_q <= {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
            err_q    <= 1'b0;
        end else begin
            if (acc0_s) begin
                fl_q[tail_q] <= rel_preg0;
            end
            if (acc1_s) begin
                fl_q[wr1_idx_s] <= rel_preg1;
            end
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            bitmap_q <= bitmap_d;
            err_q    <= err_d;
        end
    end

    assign free_count  = count_q;
    assign err_release = err_q;

endmodule
